// File: rtl/seq_mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl_pkg
// Purpose  : Shared state encoding and default width for the shift-add
//            sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_ctrl_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_mult_ctrl_pkg
`default_nettype wire

// File: rtl/seq_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl_if
// Purpose  : Request/result bundle between the operand source and the
//            sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_mult_ctrl_if
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b,
        input  busy, done, product
    );

    // Multiplier side
    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface : seq_mult_ctrl_if
`default_nettype wire

// File: rtl/seq_mult_ctrl_register_nbit.sv
`default_nettype none
// ============================================================================
// Module   : register_nbit
// Purpose  : Loadable N-bit register with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module register_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (ld) begin
            out <= in;
        end
    end

endmodule : register_nbit
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl
// Purpose  : Unsigned shift-add multiplier; WIDTH iterations per product,
//            FSM-driven load enables for the operand and product registers.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic           clk,
    input  logic           rst,
    seq_mult_ctrl_if.slave bus
);

    localparam int                 c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_count;

    logic [WIDTH-1:0]     w_m;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_shifted;
    logic                 w_carry_next;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_q_next;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == CALC) && (r_count == c_last);

    // Conditional add and right shift of {carry,acc,Q} resolve in one cycle
    assign w_addend  = {r_carry, r_acc};
    assign w_sum     = r_q[0] ? (w_addend + {1'b0, w_m}) : w_addend;
    assign w_shifted = {1'b0, w_sum, r_q[WIDTH-1:1]};
    assign {w_carry_next, w_acc_next, w_q_next} = w_shifted;

    register_nbit #(
        .WIDTH (WIDTH)
    ) u_m_reg (
        .clk (clk),
        .rst (rst),
        .ld  (w_accept),
        .in  (bus.a),
        .out (w_m)
    );

    // Product updates only on the final iteration edge, so it holds across later CALCs
    register_nbit #(
        .WIDTH (2 * WIDTH)
    ) u_product_reg (
        .clk (clk),
        .rst (rst),
        .ld  (w_last),
        .in  ({w_acc_next, w_q_next}),
        .out (bus.product)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_q     <= bus.b;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_carry <= w_carry_next;
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + c_cnt_w'(1);
                    if (r_count == c_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (r_state == CALC);
    assign bus.done = (r_state == DONE);

endmodule : seq_mult_ctrl
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_ctrl
// Purpose  : Directed self-checking bench for the 4x4 sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_ctrl;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_mult_ctrl_if #(.WIDTH(W)) bus ();

    seq_mult_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One multiply with a single-cycle start; checks busy/done timing and result
    task automatic mult(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] exp);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        chk({tag, " calc1"}, {14'd0, bus.busy, bus.done}, 16'b10);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("%s calc%0d", tag, i), {14'd0, bus.busy, bus.done}, 16'b10);
        end
        step();
        chk({tag, " done"}, {14'd0, bus.busy, bus.done}, 16'b01);
        chk({tag, " product"}, {8'd0, bus.product}, {8'd0, exp});
        step();
        chk({tag, " idle"}, {14'd0, bus.busy, bus.done}, 16'b00);
        chk({tag, " hold"}, {8'd0, bus.product}, {8'd0, exp});
    endtask

    initial begin
        logic [3:0] av;
        logic [3:0] bv;
        int         dcnt;
        int         dpos;
        logic [7:0] got;

        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset held with random stimulus
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset outputs", {7'd0, bus.busy, bus.done, bus.product}, 16'd0);
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = 4'($urandom);
            bus.b     = 4'($urandom);
        end
        bus.start = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post-reset quiet", {7'd0, bus.busy, bus.done, bus.product}, 16'd0);
        end

        mult("13x11", 4'd13, 4'd11, 8'd143);
        step();
        chk("13x11 hold2", {8'd0, bus.product}, 16'd143);

        mult("0x9",   4'd0,  4'd9,  8'd0);
        mult("15x15", 4'd15, 4'd15, 8'hE1);
        mult("1x15",  4'd1,  4'd15, 8'd15);
        mult("15x1",  4'd15, 4'd1,  8'd15);

        // Start re-asserted during CALC and DONE must be ignored
        bus.a     = 4'd2;
        bus.b     = 4'd3;
        bus.start = 1'b1;
        step();
        bus.a = 4'd7;
        bus.b = 4'd7;
        chk("ign calc1", {14'd0, bus.busy, bus.done}, 16'b10);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("ign calc%0d", i), {14'd0, bus.busy, bus.done}, 16'b10);
            chk($sformatf("ign hold%0d", i), {8'd0, bus.product}, 16'd15);
        end
        step();
        chk("ign done", {14'd0, bus.busy, bus.done}, 16'b01);
        chk("ign product", {8'd0, bus.product}, 16'd6);
        step();
        chk("ign start in done", {14'd0, bus.busy, bus.done}, 16'b00);
        bus.start = 1'b0;
        step();
        chk("ign idle", {14'd0, bus.busy, bus.done}, 16'b00);
        chk("ign product hold", {8'd0, bus.product}, 16'd6);

        // Asynchronous reset in the second CALC cycle
        bus.a     = 4'd12;
        bus.b     = 4'd12;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("abort pre busy", {15'd0, bus.busy}, 16'd1);
        rst = 1'b0;
        #1;
        chk("abort async", {7'd0, bus.busy, bus.done, bus.product}, 16'd0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("abort quiet%0d", i), {7'd0, bus.busy, bus.done, bus.product}, 16'd0);
        end
        mult("12x12", 4'd12, 4'd12, 8'd144);

        // All operand pairs with start held high
        bus.start = 1'b1;
        for (int p = 0; p < 256; p++) begin
            av    = 4'(p >> 4);
            bv    = 4'(p);
            bus.a = av;
            bus.b = bv;
            dcnt  = 0;
            dpos  = 0;
            got   = '0;
            for (int j = 1; j <= 6; j++) begin
                step();
                if (bus.done) begin
                    dcnt++;
                    dpos = j;
                    got  = bus.product;
                end
            end
            chk($sformatf("b2b %0dx%0d done count", av, bv), 16'(dcnt), 16'd1);
            chk($sformatf("b2b %0dx%0d done cycle", av, bv), 16'(dpos), 16'd5);
            chk($sformatf("b2b %0dx%0d product", av, bv), {8'd0, got},
                {8'd0, 8'(av) * 8'(bv)});
        end
        bus.start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mult_ctrl
`default_nettype wire

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Sequential shift-add unsigned multiplier: accepts a start request with two WIDTH-bit operands and produces a 2*WIDTH-bit product after WIDTH iteration cycles.
- Drives the load enables of its internal operand, accumulator and product registers from an FSM. It is the initiator side of the ld/in register interface used across the multiplier datapath.
- Sits between the top-level operand inputs and the product output of the 4x4 multiplier.

Parameters:
- WIDTH, 4, operand width in bits. Product is 2*WIDTH bits. Iteration count is WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk)
- start  input  1  request to begin a multiply; sampled only in IDLE
- a  input  WIDTH  multiplicand; captured on accepted start
- b  input  WIDTH  multiplier; captured on accepted start
- busy  output  1  high while a multiply is in progress (CALC state)
- done  output  1  one-cycle pulse; product valid and updated
- product  output  2*WIDTH  last completed result; held until next completion

Behaviour:
- Reset (rst=0, async), for every register:
  - state=IDLE, busy=0, done=0, product=0
  - multiplicand reg=0, acc=0, Q reg=0, carry=0, count=0
  - Reset mid-operation aborts the multiply; the partial result is discarded and the product is cleared to 0.
- States are IDLE, CALC, DONE; busy and done decode directly from the state register (no extra pipeline).
- IDLE:
  - On a rising edge with start=1: M<=a, Q<=b, acc<=0, carry<=0, count<=0, go to CALC.
  - With start=0: remain in IDLE.
- CALC, each cycle:
  - If Q[0]=1: {carry,acc} <= acc + M (WIDTH+1-bit sum); otherwise carry=0 and acc unchanged.
  - Then shift right {carry,acc,Q} by one bit, with zero into the MSB. Both steps happen in the same edge, combinationally.
  - count<=count+1.
  - When count==WIDTH-1 at the edge, go to DONE and load product<={acc,Q} with the final shifted value.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start accepted at edge k; done is high during the cycle following edge k+WIDTH (WIDTH=4: the 5th cycle after the accepting edge).
- Handshake rules:
  - start during CALC or DONE is ignored. No queuing and no error.
  - start held high continuously: a new multiply is accepted at the first edge spent in IDLE. Back-to-back throughput is one result per WIDTH+2 cycles.
- Operands a/b may change freely after the accepting edge; only the captured copies are used.
- Arithmetic is unsigned only:
  - count width is clog2(WIDTH)+1; it never wraps within an operation.
  - Max result (2^WIDTH-1)^2 fits in 2*WIDTH bits with no overflow.
- product changes only on the DONE-entry edge or on reset. It is stable at all other times, including during a subsequent CALC.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - default WIDTH constant
- One natural sub-module: register_nbit (parameterised width, clk, active-low async rst, ld, in, out). Instantiate it for M and for product, with ld driven by the FSM.
- acc/Q/carry shift logic stays inline in this module.

Test Plan:
- Reset: hold rst=0 with random start/a/b -> product=0, busy=0, done=0. Release; no activity until start.
- Basic: a=13, b=11, start one cycle -> busy high 4 cycles, done pulse in 5th cycle, product=8'd143. product then holds 143.
- Corners: 0*9 -> 0; 15*15 -> 8'hE1 (225); 1*15 -> 15; 15*1 -> 15. Each has exact 5-cycle latency.
- Ignored start: start=1 with a=2,b=3, then start=1 again in CALC with a=7,b=7 -> single done, product=6. Latency unchanged.
- Reset mid-op: start 12*12, pull rst=0 in 2nd CALC cycle -> immediate IDLE, product=0, no done. Restart 12*12 -> 144.
- Exhaustive back-to-back: start held high, all 256 (a,b) pairs presented each IDLE -> every done matches a*b. Exactly one done per 6 cycles.
